// File: rtl/rtc_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rtc_bus_pkg
//  Purpose : Shared types, default timing and channel indices for the RTC
//            multiplexed address/data bus master.
//  Revision: 1.0  initial release
// ============================================================================
package rtc_bus_pkg;

   // Default geometry and phase timing (cycles)
   localparam int N_CH_DEFAULT  = 3;
   localparam int DW_DEFAULT    = 8;
   localparam int T_SU_DEFAULT  = 2;
   localparam int T_PW_DEFAULT  = 4;
   localparam int T_HD_DEFAULT  = 2;
   localparam int T_GAP_DEFAULT = 2;
   localparam int RR_DEFAULT    = 0;

   // Client channel assignment
   localparam int CH_INIT = 0;
   localparam int CH_RD   = 1;
   localparam int CH_WR   = 2;

   // Bus engine states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_A_SU = 3'd1,
      ST_A_PW = 3'd2,
      ST_A_HD = 3'd3,
      ST_D_SU = 3'd4,
      ST_D_PW = 3'd5,
      ST_D_HD = 3'd6,
      ST_GAP  = 3'd7
   } bus_state_e;

   // Pin-level control levels for one state; sel_addr picks address onto D
   typedef struct packed {
      logic ad;
      logic cs;
      logic rd;
      logic wr;
      logic oe;
      logic sel_addr;
   } bus_ctl_t;

   // Control pin levels belonging to a state (strobes active-low)
   function automatic bus_ctl_t bus_ctl(input bus_state_e st, input logic rnw);
      bus_ctl_t c;
      c = '{ad: 1'b1, cs: 1'b1, rd: 1'b1, wr: 1'b1, oe: 1'b0, sel_addr: 1'b0};
      case (st)
         ST_A_SU, ST_A_HD: begin
            c.ad = 1'b0; c.cs = 1'b0; c.oe = 1'b1; c.sel_addr = 1'b1;
         end
         ST_A_PW: begin
            c.ad = 1'b0; c.cs = 1'b0; c.oe = 1'b1; c.sel_addr = 1'b1; c.wr = 1'b0;
         end
         ST_D_SU, ST_D_HD: begin
            c.cs = 1'b0; c.oe = ~rnw;
         end
         ST_D_PW: begin
            c.cs = 1'b0; c.oe = ~rnw;
            if (rnw) c.rd = 1'b0;
            else     c.wr = 1'b0;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rtc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rtc_rr_arbiter
//  Purpose : N-way request arbiter producing a one-hot grant and its index.
//            RR=0 fixed priority (ch0 highest), RR=1 round-robin whose
//            pointer advances past the winner whenever a grant is taken.
//  Revision: 1.0  initial release
// ============================================================================
module rtc_rr_arbiter #(
   parameter int N_CH = 3,
   parameter int RR   = 0,
   localparam int c_IW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] i_req,
   input  logic            i_update,
   output logic [N_CH-1:0] o_grant,
   output logic [c_IW-1:0] o_idx
);

   localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);
   localparam logic [c_IW-1:0] c_LAST = c_IW'(N_CH - 1);

   logic [c_IW-1:0] r_ptr;
   logic [c_IW-1:0] w_start;

   // Fixed priority always searches from channel 0
   assign w_start = (RR != 0) ? r_ptr : '0;

   // First requester found walking upward from the start index, wrapping
   always_comb begin
      logic            found;
      logic [c_IW-1:0] j;
      found   = 1'b0;
      j       = '0;
      o_grant = '0;
      o_idx   = '0;
      for (int k = 0; k < N_CH; k++) begin
         j = c_IW'((int'(w_start) + k) % N_CH);
         if (!found && i_req[j]) begin
            found      = 1'b1;
            o_grant[j] = 1'b1;
            o_idx      = j;
         end
      end
   end

   // Pointer moves to the channel after the winner, only on a taken grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_ptr <= '0;
      else if (i_update)
         r_ptr <= (o_idx == c_LAST) ? '0 : o_idx + c_ONE;
   end

endmodule
`default_nettype wire

// File: rtl/rtc_bus_master.sv
`default_nettype none
// ============================================================================
//  Module  : rtc_bus_master
//  Purpose : Arbitrates N client channels and runs one timed address-phase +
//            data-phase transaction on the RTC AD/CS/RD/WR/D bus.
//            All pin outputs are registered from the next state so the pads
//            never see decode glitches.
//  Revision: 1.0  initial release
// ============================================================================
module rtc_bus_master
   import rtc_bus_pkg::*;
#(
   parameter int N_CH  = N_CH_DEFAULT,
   parameter int DW    = DW_DEFAULT,
   parameter int T_SU  = T_SU_DEFAULT,
   parameter int T_PW  = T_PW_DEFAULT,
   parameter int T_HD  = T_HD_DEFAULT,
   parameter int T_GAP = T_GAP_DEFAULT,
   parameter int RR    = RR_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_CH-1:0]   req,
   input  logic [N_CH-1:0]   rnw,
   input  logic [N_CH*DW-1:0] addr,
   input  logic [N_CH*DW-1:0] wdata,
   output logic [N_CH-1:0]   gnt,
   output logic [N_CH-1:0]   done,
   output logic [DW-1:0]     rdata,
   output logic              busy,
   output logic              AD,
   output logic              CS,
   output logic              RD,
   output logic              WR,
   output logic [DW-1:0]     d_out,
   output logic              d_oe,
   input  logic [DW-1:0]     d_in
);

   localparam int c_TMAX = (T_SU > T_PW ? T_SU : T_PW) > (T_HD > T_GAP ? T_HD : T_GAP)
                         ? (T_SU > T_PW ? T_SU : T_PW) : (T_HD > T_GAP ? T_HD : T_GAP);
   localparam int c_CW   = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;
   localparam int c_IW   = (N_CH > 1) ? $clog2(N_CH) : 1;

   // Counter reload values: each state lasts (T + 1 - 1) down to zero
   localparam logic [c_CW-1:0] c_LD_SU  = c_CW'(T_SU - 1);
   localparam logic [c_CW-1:0] c_LD_PW  = c_CW'(T_PW - 1);
   localparam logic [c_CW-1:0] c_LD_HD  = c_CW'(T_HD - 1);
   localparam logic [c_CW-1:0] c_LD_GAP = c_CW'(T_GAP - 1);
   localparam logic [c_CW-1:0] c_ONE    = c_CW'(1);

   bus_state_e      r_state, w_state_nx;
   logic [c_CW-1:0] r_cnt, w_cnt_nx;
   logic            w_last, w_take;

   logic [N_CH-1:0] w_arb_grant;
   logic [c_IW-1:0] w_arb_idx;

   logic [N_CH-1:0] r_sel;
   logic            r_rnw, w_rnw_nx;
   logic [DW-1:0]   r_addr, w_addr_nx;
   logic [DW-1:0]   r_wdata, w_wdata_nx;
   bus_ctl_t        w_ctl_nx;

   logic [N_CH-1:0] r_gnt, r_done;
   logic [DW-1:0]   r_rdata, r_dout;
   logic            r_busy, r_ad, r_cs, r_rd, r_wr, r_oe;

   rtc_rr_arbiter #(
      .N_CH (N_CH),
      .RR   (RR)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_req    (req),
      .i_update (w_take),
      .o_grant  (w_arb_grant),
      .o_idx    (w_arb_idx)
   );

   assign w_last = (r_cnt == '0);

   // Phase sequencing: each state holds until the shared down-counter empties
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt - c_ONE;
      w_take     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cnt_nx = '0;
            if (|req) begin
               w_take     = 1'b1;
               w_state_nx = ST_A_SU;
               w_cnt_nx   = c_LD_SU;
            end
         end
         ST_A_SU: if (w_last) begin w_state_nx = ST_A_PW; w_cnt_nx = c_LD_PW;  end
         ST_A_PW: if (w_last) begin w_state_nx = ST_A_HD; w_cnt_nx = c_LD_HD;  end
         ST_A_HD: if (w_last) begin w_state_nx = ST_D_SU; w_cnt_nx = c_LD_SU;  end
         ST_D_SU: if (w_last) begin w_state_nx = ST_D_PW; w_cnt_nx = c_LD_PW;  end
         ST_D_PW: if (w_last) begin w_state_nx = ST_D_HD; w_cnt_nx = c_LD_HD;  end
         ST_D_HD: if (w_last) begin w_state_nx = ST_GAP;  w_cnt_nx = c_LD_GAP; end
         ST_GAP:  if (w_last) begin w_state_nx = ST_IDLE; w_cnt_nx = '0;       end
         default: begin w_state_nx = ST_IDLE; w_cnt_nx = '0; end
      endcase
   end

   // Request fields of the winner are captured at grant and held to the end
   assign w_rnw_nx   = w_take ? rnw[w_arb_idx]                 : r_rnw;
   assign w_addr_nx  = w_take ? addr[w_arb_idx*DW +: DW]       : r_addr;
   assign w_wdata_nx = w_take ? wdata[w_arb_idx*DW +: DW]      : r_wdata;
   assign w_ctl_nx   = bus_ctl(w_state_nx, w_rnw_nx);

   // Engine state, phase counter and latched transaction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_sel   <= '0;
         r_rnw   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_rnw   <= w_rnw_nx;
         r_addr  <= w_addr_nx;
         r_wdata <= w_wdata_nx;
         if (w_take) r_sel <= w_arb_grant;
      end
   end

   // Registered pin levels and client handshakes, decoded from the next state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ad    <= 1'b1;
         r_cs    <= 1'b1;
         r_rd    <= 1'b1;
         r_wr    <= 1'b1;
         r_oe    <= 1'b0;
         r_dout  <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_busy  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_ad   <= w_ctl_nx.ad;
         r_cs   <= w_ctl_nx.cs;
         r_rd   <= w_ctl_nx.rd;
         r_wr   <= w_ctl_nx.wr;
         r_oe   <= w_ctl_nx.oe;
         r_dout <= w_ctl_nx.sel_addr ? w_addr_nx : (w_ctl_nx.oe ? w_wdata_nx : '0);
         r_gnt  <= w_take ? w_arb_grant : '0;
         r_done <= (w_state_nx == ST_GAP && w_cnt_nx == '0) ? r_sel : '0;
         r_busy <= (w_state_nx != ST_IDLE);
         // RD is still low on this edge, so the RTC is driving valid data
         if (r_state == ST_D_PW && w_last && r_rnw)
            r_rdata <= d_in;
      end
   end

   assign gnt   = r_gnt;
   assign done  = r_done;
   assign rdata = r_rdata;
   assign busy  = r_busy;
   assign AD    = r_ad;
   assign CS    = r_cs;
   assign RD    = r_rd;
   assign WR    = r_wr;
   assign d_out = r_dout;
   assign d_oe  = r_oe;

endmodule
`default_nettype wire
